s_axil_register: RTL and testbench
==================================

S_AXIL_REGISTER -- requirements
Module: s_axil_register

Interface
REQ-001 Parameter S_AXI_DATA_WIDTH, default 32, data bus width in bits; SHALL be 32.
REQ-002 Parameter S_AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter NUM_REG, default 16, number of 32-bit registers; SHALL be 16.
REQ-004 Ports SHALL be:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  reset, asynchronous, active-low.
- AWADDR  in  S_AXI_ADDR_WIDTH  write byte address.
- AWVALID  in  1; AWREADY  out  1.
- WDATA  in  S_AXI_DATA_WIDTH; WSTRB  in  S_AXI_DATA_WIDTH/8  byte enables.
- WVALID  in  1; WREADY  out  1.
- BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARADDR  in  S_AXI_ADDR_WIDTH  read byte address.
- ARVALID  in  1; ARREADY  out  1.
- RDATA  out  S_AXI_DATA_WIDTH; RRESP  out  2; RVALID  out  1; RREADY  in  1.

Function
REQ-005 The block SHALL be an AXI4-Lite slave register file of NUM_REG 32-bit registers; register index = ADDR[5:2], ADDR[1:0] ignored.
REQ-006 An address with any bit above bit 5 set SHALL be out of range: write discarded, read returns RDATA=0, response SLVERR (2'b10); in-range responses OKAY (2'b00).
REQ-007 A handshake on any channel SHALL occur only on a rising edge with VALID and READY both high.
REQ-008 Write FSM states: W_IDLE (collecting AW and W), W_RESP (BVALID high).
REQ-009 In W_IDLE, AWREADY SHALL be high until an AW handshake is captured, then low; WREADY likewise for W; READY SHALL NOT depend on VALID.
REQ-010 AW and W SHALL be accepted in either order or on the same edge; address, data and strobes SHALL be latched at their own handshake.
REQ-011 On the edge completing the second of AW/W, the write SHALL commit (byte lane i updated iff WSTRB[i]=1), FSM SHALL enter W_RESP, BVALID=1 from that edge.
REQ-012 WSTRB=0 SHALL leave the register unchanged and still respond OKAY.
REQ-013 In W_RESP, AWREADY=WREADY=0; BVALID and BRESP SHALL hold stable until the BREADY edge, after which FSM returns to W_IDLE and AWREADY=WREADY=1 from that edge.
REQ-014 Read FSM states: R_IDLE (ARREADY=1), R_DATA (RVALID=1, ARREADY=0).
REQ-015 On an AR handshake, RDATA/RRESP SHALL be loaded with the register value present before that edge, RVALID=1 from that edge (one-cycle latency).
REQ-016 RDATA, RRESP, RVALID SHALL hold stable until the RREADY edge; then RVALID=0, ARREADY=1 from that edge.
REQ-017 Read and write paths SHALL be independent; a read handshake on the same edge as a write commit to the same index SHALL return the old value.
REQ-018 At most one outstanding write and one outstanding read; no buffering beyond that.

Reset
REQ-019 ARESET=0 SHALL immediately force all registers to 0, both FSMs to idle, all outputs 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA).
REQ-020 AWREADY, WREADY, ARREADY SHALL go high on the first rising edge after ARESET rises.
REQ-021 Reset mid-transaction SHALL abort it: partially captured AW/W discarded, pending BVALID/RVALID dropped, no register update.

Verification
REQ-022 Write 0x0000_0011 to 0x08, AWVALID 3 cycles before WVALID, BREADY delayed 5 cycles -> BVALID held 5 cycles, BRESP=0; read 0x08 -> RDATA=0x11, RRESP=0.
REQ-023 Write 0xAABB_CCDD to 0x3C with WSTRB=4'b0101 after reg=0 -> read 0x3C returns 0x00BB_00DD.
REQ-024 Write to 0x40 -> BRESP=2'b10, registers unchanged; read 0x44 -> RDATA=0, RRESP=2'b10.
REQ-025 Reg 0x04=5; same-edge AR to 0x04 and write commit of 7 to 0x04 -> RDATA=5; next read -> 7.
REQ-026 Assert ARESET=0 while BVALID pending and reg 0x00=0x1234 -> BVALID drops immediately, read 0x00 after reset returns 0.
REQ-027 Write indices 0..15 with random values 0-19 and random 1-30 cycle VALID/READY delays -> all 16 reads match; VALID/data stability asserted throughout.

Source files
------------

// File: rtl/s_axil_register.sv
// s_axil_register: AXI4-Lite slave exposing NUM_REG 32-bit registers.
// Register index is ADDR[5:2]; any address bit above bit 5 makes the
// access out of range (write dropped, read returns zero, SLVERR).
// Write and read channels run independent two-state machines, so at most
// one write and one read can be in flight at a time.
module s_axil_register #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REG          = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int         STRB_W      = S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Register storage
    logic [S_AXI_DATA_WIDTH-1:0] regs [NUM_REG];

    // Write channel state
    w_state_t                    w_state, w_state_nxt;
    logic                        aw_ready_q, aw_ready_nxt;
    logic                        w_ready_q, w_ready_nxt;
    logic                        aw_got_q, aw_got_nxt;
    logic                        w_got_q, w_got_nxt;
    logic                        bvalid_q, bvalid_nxt;
    logic [1:0]                  bresp_q, bresp_nxt;
    logic [S_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]           wstrb_q;

    // Read channel state
    r_state_t                    r_state, r_state_nxt;
    logic                        ar_ready_q, ar_ready_nxt;
    logic                        rvalid_q, rvalid_nxt;
    logic [1:0]                  rresp_q, rresp_nxt;
    logic [S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_nxt;

    // Handshakes and the effective write beat
    logic                        aw_hs, w_hs, ar_hs;
    logic                        wr_commit;
    logic [S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]           wr_strb;
    logic                        wr_in_range, rd_in_range;
    logic [3:0]                  wr_idx, rd_idx;
    logic                        unused_addr;

    assign aw_hs = AWVALID & aw_ready_q;
    assign w_hs  = WVALID & w_ready_q;
    assign ar_hs = ARVALID & ar_ready_q;

    // When a handshake completes the pair on this edge, use the live bus
    // value; otherwise use what was latched at the earlier handshake.
    assign wr_addr = aw_hs ? AWADDR : awaddr_q;
    assign wr_data = w_hs ? WDATA : wdata_q;
    assign wr_strb = w_hs ? WSTRB : wstrb_q;

    assign wr_in_range = ~|wr_addr[S_AXI_ADDR_WIDTH-1:6];
    assign rd_in_range = ~|ARADDR[S_AXI_ADDR_WIDTH-1:6];
    assign wr_idx      = wr_addr[5:2];
    assign rd_idx      = ARADDR[5:2];

    // Byte offset bits do not select anything.
    assign unused_addr = ^{wr_addr[1:0], ARADDR[1:0]};

    assign AWREADY = aw_ready_q;
    assign WREADY  = w_ready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = ar_ready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    // Write FSM next state: gather AW and W in any order, commit on the second.
    always_comb begin
        w_state_nxt  = w_state;
        aw_ready_nxt = aw_ready_q;
        w_ready_nxt  = w_ready_q;
        aw_got_nxt   = aw_got_q;
        w_got_nxt    = w_got_q;
        bvalid_nxt   = bvalid_q;
        bresp_nxt    = bresp_q;
        wr_commit    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) begin
                    wr_commit    = 1'b1;
                    w_state_nxt  = W_RESP;
                    aw_ready_nxt = 1'b0;
                    w_ready_nxt  = 1'b0;
                    aw_got_nxt   = 1'b0;
                    w_got_nxt    = 1'b0;
                    bvalid_nxt   = 1'b1;
                    bresp_nxt    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    // Each ready stays up until its own beat has been taken.
                    aw_got_nxt   = aw_got_q | aw_hs;
                    w_got_nxt    = w_got_q | w_hs;
                    aw_ready_nxt = ~(aw_got_q | aw_hs);
                    w_ready_nxt  = ~(w_got_q | w_hs);
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_nxt  = W_IDLE;
                    bvalid_nxt   = 1'b0;
                    aw_ready_nxt = 1'b1;
                    w_ready_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state and response registers.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            w_state    <= w_state_nxt;
            aw_ready_q <= aw_ready_nxt;
            w_ready_q  <= w_ready_nxt;
            aw_got_q   <= aw_got_nxt;
            w_got_q    <= w_got_nxt;
            bvalid_q   <= bvalid_nxt;
            bresp_q    <= bresp_nxt;
        end
    end

    // Latch address/data/strobes at their own handshakes; validity is
    // tracked by aw_got_q/w_got_q, so these need no reset.
    always_ff @(posedge ACLK) begin
        if (aw_hs) awaddr_q <= AWADDR;
        if (w_hs) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
        end
    end

    // Register file: byte-lane writes on commit, cleared by reset.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int i = 0; i < NUM_REG; i++) regs[i] <= '0;
        end else if (wr_commit && wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read FSM next state: sample the register contents as they stand
    // before this edge, so a same-edge write commit is not visible.
    always_comb begin
        r_state_nxt  = r_state;
        ar_ready_nxt = ar_ready_q;
        rvalid_nxt   = rvalid_q;
        rresp_nxt    = rresp_q;
        rdata_nxt    = rdata_q;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_nxt  = R_DATA;
                    ar_ready_nxt = 1'b0;
                    rvalid_nxt   = 1'b1;
                    rresp_nxt    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rdata_nxt    = rd_in_range ? regs[rd_idx] : '0;
                end else begin
                    ar_ready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    r_state_nxt  = R_IDLE;
                    rvalid_nxt   = 1'b0;
                    ar_ready_nxt = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM state and read-data registers.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            r_state    <= r_state_nxt;
            ar_ready_q <= ar_ready_nxt;
            rvalid_q   <= rvalid_nxt;
            rresp_q    <= rresp_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_s_axil_register.sv
// Testbench for s_axil_register: directed AXI4-Lite transactions with a
// queue-based scoreboard; a negedge monitor pops expected B/R responses
// as they appear and checks that pending responses stay stable.
module tb_s_axil_register;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    s_axil_register #(
        .S_AXI_DATA_WIDTH(32),
        .S_AXI_ADDR_WIDTH(32),
        .NUM_REG(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];
    logic [31:0] model [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait expired, required a handshake (t=%0t)", name, $time);
    endtask

    // Monitor: pop expectations when a response appears; check hold while stalled.
    logic        b_seen = 0, r_seen = 0;
    logic        prev_bv = 0, prev_br = 0, prev_rv = 0, prev_rr = 0;
    logic [1:0]  prev_bresp = '0;
    logic [33:0] prev_r = '0;
    always @(negedge ACLK) begin
        if (!ARESET) begin
            b_seen = 0; r_seen = 0;
            prev_bv = 0; prev_br = 0; prev_rv = 0; prev_rr = 0;
        end else begin
            if (prev_bv && !prev_br) begin
                check("b_hold_valid", BVALID, 1'b1);
                check("b_hold_resp", BRESP, prev_bresp);
            end
            if (BVALID && !b_seen) begin
                if (exp_b_q.size() == 0) timeout("b_unexpected");
                else check("bresp", BRESP, exp_b_q.pop_front());
            end
            b_seen = BVALID; prev_bv = BVALID; prev_br = BREADY; prev_bresp = BRESP;

            if (prev_rv && !prev_rr) begin
                check("r_hold_valid", RVALID, 1'b1);
                check("r_hold_resp_data", {RRESP, RDATA}, prev_r);
            end
            if (RVALID && !r_seen) begin
                if (exp_r_q.size() == 0) timeout("r_unexpected");
                else check("rresp_rdata", {RRESP, RDATA}, exp_r_q.pop_front());
            end
            r_seen = RVALID; prev_rv = RVALID; prev_rr = RREADY; prev_r = {RRESP, RDATA};
        end
    end

    task automatic aw_chan(input logic [31:0] addr, input int dly);
        repeat (dly) @(posedge ACLK);
        #1 AWADDR = addr; AWVALID = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge ACLK);
            if (AWREADY) break;
            if (n == 200) begin timeout("aw_ready"); break; end
        end
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
    endtask

    task automatic w_chan(input logic [31:0] data, input logic [3:0] strb, input int dly);
        repeat (dly) @(posedge ACLK);
        #1 WDATA = data; WSTRB = strb; WVALID = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge ACLK);
            if (WREADY) break;
            if (n == 200) begin timeout("w_ready"); break; end
        end
        @(posedge ACLK);
        #1 WVALID = 1'b0;
    endtask

    task automatic ar_chan(input logic [31:0] addr, input int dly);
        repeat (dly) @(posedge ACLK);
        #1 ARADDR = addr; ARVALID = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge ACLK);
            if (ARREADY) break;
            if (n == 200) begin timeout("ar_ready"); break; end
        end
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
    endtask

    task automatic b_chan(input int dly);
        for (int n = 0; ; n++) begin
            @(negedge ACLK);
            if (BVALID) break;
            if (n == 200) begin timeout("bvalid"); return; end
        end
        repeat ((dly < 1) ? 1 : dly) @(posedge ACLK);
        #1 BREADY = 1'b1;
        @(posedge ACLK);
        #1 BREADY = 1'b0;
    endtask

    task automatic r_chan(input int dly);
        for (int n = 0; ; n++) begin
            @(negedge ACLK);
            if (RVALID) break;
            if (n == 200) begin timeout("rvalid"); return; end
        end
        repeat ((dly < 1) ? 1 : dly) @(posedge ACLK);
        #1 RREADY = 1'b1;
        @(posedge ACLK);
        #1 RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input int aw_dly, input int w_dly, input int b_dly);
        logic [3:0] idx;
        idx = addr[5:2];
        exp_b_q.push_back(exp_resp);
        fork
            aw_chan(addr, aw_dly);
            w_chan(data, strb, w_dly);
        join
        b_chan(b_dly);
        if (addr[31:6] == 26'd0) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data,
                            input int ar_dly, input int r_dly);
        exp_r_q.push_back({exp_resp, exp_data});
        ar_chan(addr, ar_dly);
        r_chan(r_dly);
    endtask

    // Assert reset a few ns after an edge, check everything is cleared, release.
    task automatic do_reset();
        @(posedge ACLK);
        #3 ARESET = 1'b0;
        #1;
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst_bresp_rresp", {BRESP, RRESP}, 4'b0000);
        check("rst_rdata", RDATA, 32'h0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        check("readys_before_first_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge ACLK);
        #1 check("readys_after_first_edge", {AWREADY, WREADY, ARREADY}, 3'b111);
    endtask

    initial begin
        #(500_000);
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        do_reset();

        // Write 0x11 to 0x08: AW 3 cycles before W, BREADY held off 5 cycles.
        axi_write(32'h08, 32'h0000_0011, 4'hF, OKAY, 0, 3, 5);
        axi_read(32'h08, OKAY, 32'h0000_0011, 0, 0);

        // AW and W together; then W ahead of AW.
        axi_write(32'h10, 32'hCAFE_F00D, 4'hF, OKAY, 0, 0, 0);
        axi_write(32'h14, 32'h1234_5678, 4'hF, OKAY, 4, 0, 2);
        axi_read(32'h10, OKAY, 32'hCAFE_F00D, 2, 3);
        axi_read(32'h14, OKAY, 32'h1234_5678, 0, 1);

        // Partial strobes onto a zero register.
        axi_write(32'h3C, 32'hAABB_CCDD, 4'b0101, OKAY, 1, 1, 0);
        axi_read(32'h3C, OKAY, 32'h00BB_00DD, 0, 0);

        // No strobes: register unchanged, still OKAY.
        axi_write(32'h08, 32'hFFFF_FFFF, 4'b0000, OKAY, 0, 0, 0);
        axi_read(32'h08, OKAY, 32'h0000_0011, 0, 0);

        // Low address bits ignored: 0x1B targets index 6.
        axi_write(32'h1B, 32'h0BAD_CAFE, 4'hF, OKAY, 0, 0, 0);
        axi_read(32'h18, OKAY, 32'h0BAD_CAFE, 0, 0);

        // Out of range: write discarded, reads error with zero data.
        axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, SLVERR, 0, 0, 1);
        axi_read(32'h00, OKAY, 32'h0, 0, 0);
        axi_read(32'h44, SLVERR, 32'h0, 0, 0);
        axi_read(32'h8000_0004, SLVERR, 32'h0, 1, 0);

        // Read and write commit to index 1 on the same edge: old value returned.
        axi_write(32'h04, 32'h5, 4'hF, OKAY, 0, 0, 0);
        fork
            axi_write(32'h04, 32'h7, 4'hF, OKAY, 0, 3, 0);
            axi_read(32'h04, OKAY, 32'h5, 3, 0);
        join
        axi_read(32'h04, OKAY, 32'h7, 0, 0);

        // Reset while a write response is pending.
        axi_write(32'h00, 32'h1234, 4'hF, OKAY, 0, 0, 0);
        exp_b_q.push_back(OKAY);
        fork
            aw_chan(32'h04, 0);
            w_chan(32'h99, 4'hF, 0);
        join
        for (int n = 0; ; n++) begin
            @(negedge ACLK);
            if (BVALID) break;
            if (n == 50) begin timeout("bvalid_before_reset"); break; end
        end
        do_reset();
        axi_read(32'h00, OKAY, 32'h0, 0, 0);
        axi_read(32'h04, OKAY, 32'h0, 0, 0);

        // Reset after only AW was taken: the half write is forgotten.
        aw_chan(32'h20, 0);
        do_reset();
        axi_write(32'h24, 32'h55, 4'hF, OKAY, 0, 0, 0);
        axi_read(32'h20, OKAY, 32'h0, 0, 0);
        axi_read(32'h24, OKAY, 32'h55, 0, 0);

        // All sixteen registers with small random values and random delays.
        for (int i = 0; i < 16; i++) begin
            axi_write(i * 4, $urandom_range(0, 19), 4'hF, OKAY,
                      $urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30));
        end
        for (int i = 0; i < 16; i++) begin
            axi_read(i * 4, OKAY, model[i], $urandom_range(1, 30), $urandom_range(1, 30));
        end

        repeat (4) @(posedge ACLK);
        #1;
        check("b_queue_drained", exp_b_q.size(), 0);
        check("r_queue_drained", exp_r_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
